branch_resolver: RTL
====================

# branch_resolver

Branch resolution and predictor-training unit. Sits between the branch execution unit and the ROB commit stage, and is the writer side of the predictor's update port. At resolve time it compares predicted against actual outcome and raises a one-cycle redirect on mispredict. It holds each resolved branch in an in-order queue until commit, then drives exactly one predictor update per committed branch.

## Interface
- QUEUE_DEPTH, 4, resolved-but-uncommitted branch entries; power of 2, ≥2
- ADDR_WIDTH, 32, PC/target width (matches `AddressBus`)
- clk_in  in  1  clock; everything on posedge
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global ready; low = hold all state, no outputs change
- clear_in  in  1  pipeline flush from ROB; discards all queued entries
- resolve_valid_in  in  1  branch resolved this cycle
- resolve_ready_out  out  1  queue can accept an entry (= !full, from registered count)
- resolve_pc_in  in  ADDR_WIDTH  branch PC
- resolve_taken_in  in  1  actual direction
- resolve_target_in  in  ADDR_WIDTH  actual taken target
- resolve_pred_taken_in  in  1  direction predicted at fetch
- resolve_pred_pc_in  in  ADDR_WIDTH  next PC predicted at fetch
- commit_branch_in  in  1  ROB commits the oldest queued branch
- mispredict_out  out  1  one-cycle redirect pulse
- redirect_pc_out  out  ADDR_WIDTH  correct next PC, valid with mispredict_out
- write_enable  out  1  predictor update strobe
- write_pc  out  ADDR_WIDTH  update PC
- write_target  out  ADDR_WIDTH  update target
- write_taken  out  1  update direction

## Operation
- Queue: circular buffer. Entries hold {pc, target, taken}; head/tail pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.
- Enqueue when resolve_valid_in && resolve_ready_out. resolve_valid_in while full is a protocol violation: the entry is dropped and state is unchanged.
- Mispredict when (pred_taken != taken) || (taken && pred_pc != target).
- redirect_pc = taken ? target : pc + 4, computed with wrap-around mod 2^ADDR_WIDTH.
- A mispredicting branch is still enqueued, because it trains the predictor at commit.
- Commit with count>0: pop head and drive write_* from the head entry. Commit with count==0 is ignored and write_enable stays 0.
- Enqueue and commit in the same cycle: both happen and count is unchanged. When full, ready is already low, so no enqueue occurs.
- clear_in has priority over everything. It empties the queue (head=tail, count=0), suppresses this cycle's enqueue, commit write and mispredict, and does not touch outputs already registered.
- rst_in clears the queue and sets every output to 0 (resolve_ready_out=1 after reset).
- rdy_in low: state frozen. write_enable and mispredict_out are forced 0 in that cycle; other outputs hold.

## Timing
- All outputs are registered.
- Resolve in cycle N → mispredict_out/redirect_pc_out in N+1 for exactly one cycle.
- Commit in cycle N → write_enable plus the update fields in N+1 for one cycle. The predictor samples them at the N+1 edge, so the entry is visible to lookups from N+2.
- resolve_ready_out reflects count after the previous edge; an enqueue at N affects ready at N+1.
- Back-to-back: one resolve and one commit per cycle sustained indefinitely.

## Structure
- `branchQueueSize` and the queue pointer-width macros go in defines.v next to `AddressBus`. No package types are needed.
- Optional sub-module: branch_queue_fifo (generic storage plus pointers, with flush input). The mispredict comparator and output registers stay in branch_resolver.

## Test plan
- Reset then idle → all outputs 0, resolve_ready_out=1, commit is ignored and write_enable stays 0.
- Resolve pc=0x100, taken=1, target=0x80, pred_taken=1, pred_pc=0x80 → no mispredict. Commit two cycles later → N+1: write_enable=1, write_pc=0x100, write_target=0x80, write_taken=1.
- Resolve pc=0x200, taken=0, pred_taken=1 → N+1: mispredict_out=1, redirect_pc_out=0x204. Also pc=0xFFFFFFFC not-taken mispredict → redirect 0x0.
- Taken with wrong target: pc=0x300, target=0x400, pred_pc=0x380 → mispredict and redirect 0x400.
- Fill 4 entries with no commits → ready=0. Simultaneous resolve+commit keeps count=4 and the resolve is not accepted. The next four commits return entries in FIFO order, with the pointer wrapping correctly.
- clear_in in the same cycle as resolve and commit, with 3 entries queued → count=0, no write_enable and no mispredict next cycle. rdy_in=0 mid-stream freezes count and suppresses strobes.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared constants for the branch resolver
package branch_resolver_pkg;

    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_ADDR_WIDTH  = 32;
    // Fall-through distance for a not-taken branch
    localparam int PC_STEP         = 4;

endpackage

// File: rtl/branch_resolver_fifo.sv
// rtl/branch_resolver_fifo.sv - circular queue of resolved-but-uncommitted branches
module branch_resolver_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from the registered count so the caller's ready is stable
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[head];

    // Pointers and occupancy; flush wins, pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between head and tail
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch mispredict detection and in-order predictor training
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  resolve_valid_in,
    output logic                  resolve_ready_out,
    input  logic [ADDR_WIDTH-1:0] resolve_pc_in,
    input  logic                  resolve_taken_in,
    input  logic [ADDR_WIDTH-1:0] resolve_target_in,
    input  logic                  resolve_pred_taken_in,
    input  logic [ADDR_WIDTH-1:0] resolve_pred_pc_in,
    input  logic                  commit_branch_in,
    output logic                  mispredict_out,
    output logic [ADDR_WIDTH-1:0] redirect_pc_out,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_pc,
    output logic [ADDR_WIDTH-1:0] write_target,
    output logic                  write_taken
);
    localparam int ENTRY_W = 2 * ADDR_WIDTH + 1;

    logic                  active;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  do_commit;
    logic                  mispredict_now;
    logic [ADDR_WIDTH-1:0] redirect_now;
    logic [ENTRY_W-1:0]    head_data;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  head_taken;

    // Stall freezes everything; a flush (when not stalled) blocks both queue ports
    assign active    = rdy_in && !clear_in;
    assign push      = active && resolve_valid_in;
    assign pop       = active && commit_branch_in;
    assign flush     = rdy_in && clear_in;
    assign accept    = push && !full;
    assign do_commit = pop && !empty;

    assign resolve_ready_out = !full;

    // A taken branch with the right direction can still go to the wrong target
    assign mispredict_now = (resolve_pred_taken_in != resolve_taken_in) ||
                            (resolve_taken_in && (resolve_pred_pc_in != resolve_target_in));
    assign redirect_now   = resolve_taken_in ? resolve_target_in
                                             : resolve_pc_in + ADDR_WIDTH'(PC_STEP);

    assign {head_pc, head_target, head_taken} = head_data;

    branch_resolver_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk_in),
        .rst       (rst_in),
        .flush     (flush),
        .push      (push),
        .push_data ({resolve_pc_in, resolve_target_in, resolve_taken_in}),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    // Registered outputs: strobes last one cycle, data fields hold until next event
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mispredict_out  <= 1'b0;
            redirect_pc_out <= '0;
            write_enable    <= 1'b0;
            write_pc        <= '0;
            write_target    <= '0;
            write_taken     <= 1'b0;
        end else if (!rdy_in) begin
            mispredict_out <= 1'b0;
            write_enable   <= 1'b0;
        end else begin
            mispredict_out <= accept && mispredict_now;
            write_enable   <= do_commit;
            if (accept && mispredict_now) begin
                redirect_pc_out <= redirect_now;
            end
            if (do_commit) begin
                write_pc     <= head_pc;
                write_target <= head_target;
                write_taken  <= head_taken;
            end
        end
    end

endmodule
